sub_serial_nibble: RTL and testbench

Multi-cycle subtractor that computes a − b for the Risc5CPU ALU one 4-bit nibble per clock, propagating a registered borrow between nibbles. It mirrors the existing nibble-granular carry-select adder and provides the subtraction side needed for SUB, SLT and SLTU without a full-width combinational borrow chain. It sits beside the ALU and is controlled by a start/busy/done handshake from the execute-stage control.

---
 rtl/sub_serial_nibble_pkg.sv | 17 +
 rtl/sub_serial_nibble_if.sv | 25 ++
 rtl/sub_serial_nibble_nib.sv | 15 +
 rtl/sub_serial_nibble.sv | 120 ++++++++++++
 tb/tb_sub_serial_nibble.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/sub_serial_nibble_pkg.sv
// Shared encodings and sizing helpers for the nibble-serial subtractor.
package sub_serial_nibble_pkg;

  localparam int unsigned NIB = 4;

  typedef enum logic [1:0] {
    SubIdle = 2'd0,
    SubRun  = 2'd1,
    SubDone = 2'd2
  } sub_state_e;

  // Width of the nibble index counter; at least one bit.
  function automatic int unsigned idx_width(int unsigned width);
    return (width / NIB > 1) ? $clog2(width / NIB) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_nibble_if.sv
// Start/busy/done handshake plus operands and result flags of the serial subtractor.
interface sub_serial_nibble_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             lt;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, lt, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, lt, zero
  );
endinterface

// File: rtl/sub_serial_nibble_nib.sv
// One 4-bit subtract step with borrow in/out: {bo, d} = a - b - bi.
module nibble_sub_4bits
  import sub_serial_nibble_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           bi,
  output logic [NIB-1:0] d,
  output logic           bo
);

  // The extra top bit wraps to 1 exactly when the result goes negative.
  assign {bo, d} = {1'b0, a} - {1'b0, b} - {{NIB{1'b0}}, bi};

endmodule

// File: rtl/sub_serial_nibble.sv
// Multi-cycle a - b, one nibble per clock with a registered borrow; flags land with the last nibble.
module sub_serial_nibble
  import sub_serial_nibble_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  sub_serial_nibble_if.slave bus
);

  localparam int unsigned NumNib = WIDTH / NIB;
  localparam int unsigned IdxW   = idx_width(WIDTH);

  sub_state_e       state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             borrow_reg_q, borrow_reg_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             lt_q, lt_d;
  logic             zero_q, zero_d;

  logic [NIB-1:0]   a_nib, b_nib, nib_d;
  logic             nib_bo;

  assign a_nib = a_q[{idx_q, 2'b00} +: NIB];
  assign b_nib = b_q[{idx_q, 2'b00} +: NIB];

  nibble_sub_4bits u_nib (
    .a  (a_nib),
    .b  (b_nib),
    .bi (borrow_reg_q),
    .d  (nib_d),
    .bo (nib_bo)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_reg_d = borrow_reg_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    ovf_d        = ovf_q;
    lt_d         = lt_q;
    zero_d       = zero_q;

    case (state_q)
      SubIdle, SubDone: begin
        if (bus.start) begin
          a_d          = bus.a;
          b_d          = bus.b;
          borrow_reg_d = 1'b0;
          idx_d        = '0;
          diff_d       = '0;
          borrow_d     = 1'b0;
          ovf_d        = 1'b0;
          lt_d         = 1'b0;
          zero_d       = 1'b0;
          state_d      = SubRun;
        end else begin
          state_d = SubIdle;
        end
      end
      SubRun: begin
        diff_d[{idx_q, 2'b00} +: NIB] = nib_d;
        borrow_reg_d = nib_bo;
        idx_d        = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NumNib - 1)) begin
          // diff_d is complete here, so the flags are valid at the same edge.
          state_d  = SubDone;
          borrow_d = nib_bo;
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          lt_d     = diff_d[WIDTH-1] ^ ovf_d;
          zero_d   = (diff_d == '0);
        end
      end
      default: state_d = SubIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= SubIdle;
      idx_q        <= '0;
      borrow_reg_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      ovf_q        <= 1'b0;
      lt_q         <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_reg_q <= borrow_reg_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      ovf_q        <= ovf_d;
      lt_q         <= lt_d;
      zero_q       <= zero_d;
    end
  end

  assign bus.busy   = (state_q == SubRun);
  assign bus.done   = (state_q == SubDone);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
  assign bus.lt     = lt_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_sub_serial_nibble.sv
// Directed bench for sub_serial_nibble: arithmetic reference model plus literal checks.
module tb_sub_serial_nibble;

  localparam int unsigned W = 32;
  localparam int unsigned N = W / 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   chk_en;

  sub_serial_nibble_if #(.WIDTH(W)) bus ();

  sub_serial_nibble #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a cycle budget per operation, results from plain arithmetic.
  logic          m_busy, m_done, m_bor, m_ovf, m_lt, m_zero;
  logic [W-1:0]  m_diff;
  logic [W-1:0]  p_diff;
  logic          p_bor, p_ovf, p_lt, p_zero;
  int            m_rem;

  always @(posedge clk) begin
    longint sa, sb, sr;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_diff = '0;
      m_bor = 0; m_ovf = 0; m_lt = 0; m_zero = 0; m_rem = 0;
    end else if (!m_busy && bus.start) begin
      sa = longint'($signed(bus.a));
      sb = longint'($signed(bus.b));
      sr = sa - sb;
      p_diff = bus.a - bus.b;
      p_bor  = (bus.a < bus.b);
      p_ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      p_lt   = (sa < sb);
      p_zero = (bus.a == bus.b);
      m_busy = 1; m_done = 0; m_diff = '0;
      m_bor = 0; m_ovf = 0; m_lt = 0; m_zero = 0;
      m_rem = N;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
        m_diff = p_diff; m_bor = p_bor; m_ovf = p_ovf; m_lt = p_lt; m_zero = p_zero;
      end
    end else begin
      m_done = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", 32'(bus.busy), 32'(m_busy));
      chk("m_done", 32'(bus.done), 32'(m_done));
      if (!m_busy) begin
        chk("m_diff", bus.diff, m_diff);
        chk("m_borrow", 32'(bus.borrow), 32'(m_bor));
        chk("m_ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("m_lt", 32'(bus.lt), 32'(m_lt));
        chk("m_zero", 32'(bus.zero), 32'(m_zero));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(string nm, logic [31:0] av, logic [31:0] bv, logic [31:0] ed,
                        logic eb, logic eo, logic el, logic ez);
    int cyc;
    bus.start = 1'b1; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done_cycle"}, cyc, 9);
    chk({nm, "_diff"}, bus.diff, ed);
    chk({nm, "_borrow"}, 32'(bus.borrow), 32'(eb));
    chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
    chk({nm, "_lt"}, 32'(bus.lt), 32'(el));
    chk({nm, "_zero"}, 32'(bus.zero), 32'(ez));
    @(negedge clk);
  endtask

  initial begin
    int first_done, second_done, ndone;
    total = 0; bad = 0; chk_en = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_flags", {28'd0, bus.borrow, bus.ovf, bus.lt, bus.zero}, 0);
    rst_n = 1'b1;
    chk_en = 1;

    run_op("5m3", 32'd5, 32'd3, 32'h0000_0002, 0, 0, 0, 0);
    run_op("3m5", 32'd3, 32'd5, 32'hFFFF_FFFE, 1, 0, 1, 0);
    run_op("minm1", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 0, 1, 1, 0);
    run_op("eq", 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 0, 0, 0, 1);
    run_op("0mff", 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 0, 0);
    run_op("mixed", 32'h7000_0000, 32'h9000_0000, 32'hE000_0000, 1, 1, 0, 0);

    // Starts while busy are ignored; start held in the done cycle chains a second op.
    bus.start = 1'b1; bus.a = 32'h0F0F_0F0F; bus.b = 32'h0123_4567;
    @(negedge clk);
    first_done = 0; second_done = 0; ndone = 0;
    for (int c = 1; c <= 22; c++) begin
      if (bus.done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = c;
          chk("ign_diff1", bus.diff, 32'h0DEB_C9A8);
        end else if (second_done == 0) begin
          second_done = c;
          chk("b2b_diff2", bus.diff, 32'h0000_0064);
        end
      end
      bus.start = (c == 3 || c == 5 || c == 9);
      bus.a = (c == 9) ? 32'd200 : $urandom;
      bus.b = (c == 9) ? 32'd100 : $urandom;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("ign_first_done", first_done, 9);
    chk("b2b_second_done", second_done, 18);
    chk("ign_done_count", ndone, 2);

    // Reset in cycle 4 aborts the op with partially written nonzero diff.
    bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'h0;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 15; c++) begin
      if (bus.done) ndone++;
      if (c == 5) begin
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_diff", bus.diff, 0);
        chk("abort_flags", {28'd0, bus.borrow, bus.ovf, bus.lt, bus.zero}, 0);
      end
      rst_n = (c != 4);
      @(negedge clk);
    end
    rst_n = 1'b1;
    chk("abort_no_done", ndone, 0);

    run_op("post_rst", 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h4B4B_4B4B, 0, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
